univ_shift_reg: RTL
===================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register length in bits (legal range 2..64).
REQ-002 SHALL have localparam CW = $clog2(WIDTH), the width of shift_cnt.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  clock enable; 0 holds all state.
REQ-006 SHALL have port mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 SHALL have port sin  input  1  serial data in.
REQ-008 SHALL have port pin  input  WIDTH  parallel data in.
REQ-009 SHALL have port q  output  WIDTH  register contents, registered.
REQ-010 SHALL have port sout  output  1  serial data out.
REQ-011 SHALL have port shift_cnt  output  CW  shifts completed in the current frame, registered.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when a WIDTH-bit frame completes, registered.

Function
REQ-013 SHALL update state only on rising clk with en=1 and rst_n=1.
REQ-014 Shift right (01) SHALL load q <= {sin, q[WIDTH-1:1]}.
REQ-015 Shift left (10) SHALL load q <= {q[WIDTH-2:0], sin}.
REQ-016 Parallel load (11) SHALL load q <= pin, clear shift_cnt to 0 and drive frame_done 0.
REQ-017 Hold (00) SHALL keep q and shift_cnt unchanged and drive frame_done 0.
REQ-018 sout SHALL be combinational: q[WIDTH-1] when mode=10, otherwise q[0].
REQ-019 In right-shift mode, a bit sampled on sin at edge N SHALL appear on sout after edge N+WIDTH-1. For WIDTH=4 this is a 4-flop SISO chain.
REQ-020 On every enabled shift, shift_cnt SHALL increment by 1.
REQ-021 On an enabled shift with shift_cnt=WIDTH-1, shift_cnt SHALL wrap to 0 and frame_done SHALL be 1 for the following cycle.
REQ-022 At that point q SHALL hold the complete WIDTH-bit frame.
REQ-023 frame_done SHALL be 0 in every cycle not covered by REQ-021.
REQ-024 A mode change between right and left shifts SHALL NOT clear shift_cnt; the frame count continues.
REQ-025 en=0 SHALL freeze q and shift_cnt and force frame_done to 0 on the next edge, regardless of mode.
REQ-026 Parallel load SHALL take priority over frame completion: load in the cycle after a frame-completing shift leaves frame_done cleared on the following edge.

Reset
REQ-027 While rst_n=0, q SHALL be 0, shift_cnt SHALL be 0 and frame_done SHALL be 0, immediately and without a clock.
REQ-028 With q=0, sout SHALL be 0 during reset.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; the first enabled shift after release SHALL count as shift 1.
REQ-030 Reset release SHALL take effect at the first rising clk with rst_n=1.

Verification
REQ-031 Scenario, SISO right: WIDTH=4, mode=01, en=1, sin sequence 1,0,1,1 on edges 1-4 -> sout shows 1 after edge 4; q=4'b1101 after edge 4; frame_done=1 for the cycle after edge 4; shift_cnt=0.
REQ-032 Scenario, PISO left: load pin=4'b1001 with mode=11, then mode=10 with sin=0 for 4 edges -> sout reads 1,0,0,1 across cycles; q=0 at the end; frame_done pulses once.
REQ-033 Scenario, enable gap: right shift with en=0 for 3 cycles mid-frame -> q and shift_cnt frozen; frame_done occurs only after 4 enabled shifts in total.
REQ-034 Scenario, mid-frame reset: after 2 shifts, pulse rst_n low between edges -> q, shift_cnt and frame_done go to 0 asynchronously; the next 4 shifts produce exactly one frame_done.
REQ-035 Scenario, load after shifts: 3 right shifts then load pin=4'hA -> q=4'hA, shift_cnt=0, no frame_done; 4 further shifts -> one frame_done.
REQ-036 Scenario, hold and WIDTH=8: mode=00 for 5 cycles -> q unchanged; 8 left shifts -> frame_done once with shift_cnt wrapped to 0.

Source files
------------

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with frame counter
//
// Purpose : WIDTH-bit register supporting hold, shift right, shift left and
//           parallel load, with a shift counter that marks completed
//           WIDTH-bit serial frames.
// Ports   :
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   clock enable, 0 holds all state
//   mode       in   00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin        in   serial data in
//   pin        in   parallel data in [WIDTH]
//   q          out  register contents (registered) [WIDTH]
//   sout       out  serial data out (combinational from q and mode)
//   shift_cnt  out  shifts completed in current frame (registered) [CW]
//   frame_done out  one-cycle pulse after a frame-completing shift (registered)

module univ_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       sin,
    input  logic [WIDTH-1:0]           pin,
    output logic [WIDTH-1:0]           q,
    output logic                       sout,
    output logic [$clog2(WIDTH)-1:0]   shift_cnt,
    output logic                       frame_done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             do_shift;

    always_comb begin
        q_d          = q_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        do_shift     = 1'b0;

        if (en) begin
            case (mode)
                MODE_RIGHT: begin
                    q_d      = {sin, q_q[WIDTH-1:1]};
                    do_shift = 1'b1;
                end
                MODE_LEFT: begin
                    q_d      = {q_q[WIDTH-2:0], sin};
                    do_shift = 1'b1;
                end
                MODE_LOAD: begin
                    // A load starts a fresh frame, so any pending count is dropped.
                    q_d   = pin;
                    cnt_d = '0;
                end
                MODE_HOLD: begin
                    q_d = q_q;
                end
                default: begin
                    q_d = q_q;
                end
            endcase

            // Direction changes do not restart the frame; every shift counts.
            if (do_shift) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q          <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign q          = q_q;
    assign shift_cnt  = cnt_q;
    assign frame_done = frame_done_q;
    // Left shifts emit the MSB, everything else presents the LSB.
    assign sout       = (mode == MODE_LEFT) ? q_q[WIDTH-1] : q_q[0];

endmodule
